// File: rtl/encoder_ctrl_pkg.sv
// Shared types and constants for the encoder axis move sequencer.
package encoder_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOME_SEEK,
        ST_HOME_CLEAR,
        ST_READY,
        ST_MOVE,
        ST_SETTLE,
        ST_FAULT
    } state_e;

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_HOME_TMO = 2'd1;
    localparam logic [1:0] FAULT_MOVE_TMO = 2'd2;

    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_CCW = 1'b0;

    function automatic logic is_busy(input state_e s);
        return (s == ST_HOME_SEEK) || (s == ST_HOME_CLEAR) ||
               (s == ST_MOVE) || (s == ST_SETTLE);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs
// (home switch, encoder A/B).
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/encoder_move_sequencer.sv
// Closed-loop homing and move sequencer for one quadrature-encoded axis.
// Owns the decoder clear pulse and drives motor enable/direction.
module encoder_move_sequencer
    import encoder_ctrl_pkg::*;
#(
    parameter int POS_W         = 16,
    parameter int TMO_W         = 20,
    parameter int DEADBAND      = 2,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    home_req,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic signed [POS_W-1:0] cmd_target,
    input  logic signed [POS_W-1:0] position,
    input  logic                    home_sw,
    input  logic        [TMO_W-1:0] timeout_limit,
    input  logic                    fault_clr,
    output logic                    pos_clear,
    output logic                    motor_en,
    output logic                    motor_dir,
    output logic                    busy,
    output logic                    done,
    output logic                    homed,
    output logic                    fault,
    output logic        [1:0]       fault_code
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic signed [POS_W:0] DB_P = (POS_W + 1)'(DEADBAND);
    localparam logic signed [POS_W:0] DB_N = -DB_P;

    logic home_sw_s;

    sync_2ff #(.WIDTH(1)) u_home_sync (
        .clk   (clk),
        .reset (reset),
        .d     (home_sw),
        .q     (home_sw_s)
    );

    state_e                  state_q, state_d;
    logic signed [POS_W-1:0] target_q, target_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [SET_W-1:0]        settle_q, settle_d;
    logic                    pos_clear_q, pos_clear_d;
    logic                    motor_en_q, motor_en_d;
    logic                    motor_dir_q, motor_dir_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    homed_q, homed_d;
    logic                    fault_q, fault_d;
    logic [1:0]              fault_code_q, fault_code_d;

    // One extra bit so full-scale opposite extremes never wrap.
    logic signed [POS_W:0] err;
    logic                  in_band;
    logic [TMO_W-1:0]      tmo_inc;
    logic                  tmo_hit;
    logic [SET_W-1:0]      settle_inc;
    logic                  settle_done;

    assign err = $signed({target_q[POS_W-1], target_q}) -
                 $signed({position[POS_W-1], position});
    assign in_band = (err <= DB_P) && (err >= DB_N);

    assign tmo_inc = tmo_q + TMO_W'(1);
    assign tmo_hit = (timeout_limit != '0) && (tmo_inc >= timeout_limit);

    assign settle_inc  = settle_q + SET_W'(1);
    assign settle_done = (settle_inc == SET_W'(SETTLE_CYCLES));

    assign cmd_ready = (state_q == ST_READY) && !home_req;

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        tmo_d        = tmo_q;
        settle_d     = settle_q;
        pos_clear_d  = 1'b0;
        motor_en_d   = 1'b0;
        motor_dir_d  = motor_dir_q;
        done_d       = 1'b0;
        homed_d      = homed_q;
        fault_code_d = fault_code_q;

        unique case (state_q)
            ST_IDLE: begin
                if (home_req) begin
                    state_d     = ST_HOME_SEEK;
                    tmo_d       = '0;
                    motor_en_d  = 1'b1;
                    motor_dir_d = DIR_CCW;
                end
            end
            ST_HOME_SEEK: begin
                tmo_d = tmo_inc;
                if (home_sw_s) begin
                    state_d     = ST_HOME_CLEAR;
                    pos_clear_d = 1'b1;
                end else if (tmo_hit) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FAULT_HOME_TMO;
                    homed_d      = 1'b0;
                end else begin
                    motor_en_d  = 1'b1;
                    motor_dir_d = DIR_CCW;
                end
            end
            ST_HOME_CLEAR: begin
                state_d = ST_READY;
                homed_d = 1'b1;
            end
            ST_READY: begin
                if (home_req) begin
                    state_d     = ST_HOME_SEEK;
                    tmo_d       = '0;
                    motor_en_d  = 1'b1;
                    motor_dir_d = DIR_CCW;
                end else if (cmd_valid) begin
                    state_d  = ST_MOVE;
                    target_d = cmd_target;
                    tmo_d    = '0;
                    settle_d = '0;
                end
            end
            ST_MOVE: begin
                tmo_d = tmo_inc;
                if (tmo_hit) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FAULT_MOVE_TMO;
                    homed_d      = 1'b0;
                end else if (in_band) begin
                    state_d  = ST_SETTLE;
                    settle_d = SET_W'(1);
                end else begin
                    motor_en_d  = 1'b1;
                    motor_dir_d = (err > 0) ? DIR_CW : DIR_CCW;
                end
            end
            ST_SETTLE: begin
                tmo_d = tmo_inc;
                if (in_band && settle_done) begin
                    state_d = ST_READY;
                    done_d  = 1'b1;
                end else if (tmo_hit) begin
                    state_d      = ST_FAULT;
                    fault_code_d = FAULT_MOVE_TMO;
                    homed_d      = 1'b0;
                end else if (!in_band) begin
                    state_d  = ST_MOVE;
                    settle_d = '0;
                end else begin
                    settle_d = settle_inc;
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_d      = ST_IDLE;
                    fault_code_d = FAULT_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d  = is_busy(state_d);
        fault_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            target_q     <= '0;
            tmo_q        <= '0;
            settle_q     <= '0;
            pos_clear_q  <= 1'b0;
            motor_en_q   <= 1'b0;
            motor_dir_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            homed_q      <= 1'b0;
            fault_q      <= 1'b0;
            fault_code_q <= FAULT_NONE;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            tmo_q        <= tmo_d;
            settle_q     <= settle_d;
            pos_clear_q  <= pos_clear_d;
            motor_en_q   <= motor_en_d;
            motor_dir_q  <= motor_dir_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            homed_q      <= homed_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign pos_clear  = pos_clear_q;
    assign motor_en   = motor_en_q;
    assign motor_dir  = motor_dir_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign homed      = homed_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;

endmodule

// File: tb/tb_encoder_move_sequencer.sv
// Self-checking bench for encoder_move_sequencer: homing, closed-loop
// moves against a simple plant, timeouts, priority and reset.
module tb_encoder_move_sequencer;

    localparam int SETTLE = 8;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               home_req = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic signed [15:0] cmd_target = '0;
    logic signed [15:0] position = '0;
    logic               home_sw = 1'b0;
    logic [19:0]        timeout_limit = '0;
    logic               fault_clr = 1'b0;
    logic               pos_clear;
    logic               motor_en;
    logic               motor_dir;
    logic               busy;
    logic               done;
    logic               homed;
    logic               fault;
    logic [1:0]         fault_code;

    int n_checks = 0;
    int n_err = 0;

    typedef struct {
        int pos0;
        int target;
        int step;
        bit ovs;
        bit exp_run;
        bit exp_dir;
    } vec_t;

    vec_t vecs[7];
    vec_t sb[$];

    encoder_move_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .home_req      (home_req),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_target    (cmd_target),
        .position      (position),
        .home_sw       (home_sw),
        .timeout_limit (timeout_limit),
        .fault_clr     (fault_clr),
        .pos_clear     (pos_clear),
        .motor_en      (motor_en),
        .motor_dir     (motor_dir),
        .busy          (busy),
        .done          (done),
        .homed         (homed),
        .fault         (fault),
        .fault_code    (fault_code)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkv(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit in_band(input int t, input int p);
        int d;
        d = t - p;
        return (d <= 2) && (d >= -2);
    endfunction

    task automatic home_now();
        bit ok;
        ok = 1'b0;
        home_sw = 1'b1;
        @(negedge clk);
        home_req = 1'b1;
        @(negedge clk);
        home_req = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = homed && !busy;
        end
        chk1("home_now", ok, 1'b1);
    endtask

    task automatic do_move(input vec_t v);
        int   p;
        int   run;
        int   tick;
        int   e;
        int   amt;
        bit   got_done;
        bit   saw_motor;
        bit   have_dir;
        logic first_dir;
        bit   d1;
        bit   d2;
        vec_t x;
        p = v.pos0;
        run = 0;
        tick = 0;
        got_done = 0;
        saw_motor = 0;
        have_dir = 0;
        first_dir = 1'b0;
        d1 = 0;
        d2 = 0;
        @(negedge clk);
        position = 16'(p);
        cmd_target = 16'(v.target);
        cmd_valid = 1'b1;
        #1;
        chk1("mv_cmd_ready", cmd_ready, 1'b1);
        sb.push_back(v);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_target = 16'h1234;
        chk1("mv_entry_en", motor_en, 1'b0);
        chk1("mv_entry_busy", busy, 1'b1);
        for (int c = 0; c < 3000 && !got_done; c++) begin
            @(negedge clk);
            run = in_band(v.target, p) ? run + 1 : 0;
            chk1("mv_done", done, run == SETTLE);
            if (motor_en === 1'b1) begin
                saw_motor = 1;
                if (!have_dir) begin
                    have_dir = 1;
                    first_dir = motor_dir;
                end
                chk1("mv_dir", motor_dir, v.target > p);
            end
            if (done === 1'b1) begin
                got_done = 1;
                chk1("mv_ready_after", busy, 1'b0);
            end else if (v.ovs && run == 3 && !d1) begin
                d1 = 1;
                p = v.target + 1;
            end else if (v.ovs && run == 5 && !d2) begin
                d2 = 1;
                p = v.target + 3;
            end else if (motor_en === 1'b1) begin
                tick++;
                if (tick % 4 == 0) begin
                    e = v.target - p;
                    amt = (e < 0) ? -e : e;
                    if (amt > v.step) amt = v.step;
                    p = motor_dir ? p + amt : p - amt;
                end
            end
            position = 16'(p);
        end
        chk1("mv_done_seen", got_done, 1'b1);
        if (sb.size() == 0) begin
            chk1("sb_empty", 1'b0, 1'b1);
        end else begin
            x = sb.pop_front();
            chk1("sb_motor", saw_motor, x.exp_run);
            if (x.exp_run) chk1("sb_dir", first_dir, x.exp_dir);
            chk1("sb_final_band", in_band(x.target, p), 1'b1);
        end
    endtask

    initial begin
        bit ok;
        vecs[0] = '{pos0: 0,      target: 40,     step: 1,
                    ovs: 0, exp_run: 1, exp_dir: 1};
        vecs[1] = '{pos0: 0,      target: -100,   step: 1,
                    ovs: 1, exp_run: 1, exp_dir: 0};
        vecs[2] = '{pos0: 5,      target: 6,      step: 1,
                    ovs: 0, exp_run: 0, exp_dir: 0};
        vecs[3] = '{pos0: 10,     target: 7,      step: 1,
                    ovs: 0, exp_run: 1, exp_dir: 0};
        vecs[4] = '{pos0: 10,     target: 12,     step: 1,
                    ovs: 0, exp_run: 0, exp_dir: 0};
        vecs[5] = '{pos0: -32768, target: 32767,  step: 16384,
                    ovs: 0, exp_run: 1, exp_dir: 1};
        vecs[6] = '{pos0: 32767,  target: -32768, step: 16384,
                    ovs: 0, exp_run: 1, exp_dir: 0};

        // Reset state
        @(negedge clk);
        chk1("rst_motor_en", motor_en, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_homed", homed, 1'b0);
        chk1("rst_fault", fault, 1'b0);
        chk1("rst_pos_clear", pos_clear, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_cmd_ready", cmd_ready, 1'b0);
        chkv("rst_fault_code", {30'b0, fault_code}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Homing with a late home switch
        @(negedge clk);
        home_req = 1'b1;
        @(negedge clk);
        home_req = 1'b0;
        chk1("seek_en", motor_en, 1'b1);
        chk1("seek_dir", motor_dir, 1'b0);
        chk1("seek_busy", busy, 1'b1);
        ok = 1'b1;
        repeat (49) begin
            @(negedge clk);
            ok = ok && (motor_en === 1'b1) && (motor_dir === 1'b0) &&
                 (pos_clear === 1'b0);
        end
        chk1("seek_hold", ok, 1'b1);
        home_sw = 1'b1;
        @(negedge clk);
        chk1("clr_wait1", pos_clear, 1'b0);
        @(negedge clk);
        chk1("clr_wait2", pos_clear, 1'b0);
        @(negedge clk);
        chk1("clr_pulse", pos_clear, 1'b1);
        chk1("clr_motor_off", motor_en, 1'b0);
        @(negedge clk);
        chk1("clr_end", pos_clear, 1'b0);
        chk1("homed", homed, 1'b1);
        chk1("ready_busy", busy, 1'b0);
        chk1("ready_cmd_ready", cmd_ready, 1'b1);

        // Table-driven moves
        foreach (vecs[i]) do_move(vecs[i]);
        chkv("sb_drained", sb.size(), 32'd0);

        // home_req wins over a simultaneous command
        @(negedge clk);
        home_req = 1'b1;
        cmd_valid = 1'b1;
        cmd_target = 16'sd500;
        #1;
        chk1("prio_cmd_ready", cmd_ready, 1'b0);
        @(negedge clk);
        home_req = 1'b0;
        cmd_valid = 1'b0;
        chk1("prio_seek_busy", busy, 1'b1);
        chk1("prio_seek_en", motor_en, 1'b1);
        chk1("prio_seek_dir", motor_dir, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            chk1("prio_no_done", done, 1'b0);
            ok = !busy;
        end
        chk1("prio_back_ready", ok, 1'b1);
        chk1("prio_homed", homed, 1'b1);
        chk1("prio_cmd_ready2", cmd_ready, 1'b1);

        // Home-seek timeout
        home_sw = 1'b0;
        repeat (3) @(negedge clk);
        timeout_limit = 20'd100;
        home_req = 1'b1;
        @(negedge clk);
        home_req = 1'b0;
        chk1("htmo_busy", busy, 1'b1);
        repeat (99) @(negedge clk);
        chk1("htmo_not_yet", fault, 1'b0);
        @(negedge clk);
        chk1("htmo_fault", fault, 1'b1);
        chkv("htmo_code", {30'b0, fault_code}, 32'd1);
        chk1("htmo_motor", motor_en, 1'b0);
        chk1("htmo_homed", homed, 1'b0);
        chk1("htmo_busy_off", busy, 1'b0);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        chk1("fclr_fault", fault, 1'b0);
        chkv("fclr_code", {30'b0, fault_code}, 32'd0);
        cmd_valid = 1'b1;
        #1;
        chk1("idle_cmd_ready", cmd_ready, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk1("idle_busy", busy, 1'b0);

        // Move timeout
        home_now();
        timeout_limit = 20'd30;
        position = '0;
        @(negedge clk);
        cmd_target = 16'sd1000;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (29) @(negedge clk);
        chk1("mtmo_not_yet", fault, 1'b0);
        @(negedge clk);
        chk1("mtmo_fault", fault, 1'b1);
        chkv("mtmo_code", {30'b0, fault_code}, 32'd2);
        chk1("mtmo_motor", motor_en, 1'b0);
        chk1("mtmo_homed", homed, 1'b0);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        timeout_limit = '0;

        // Asynchronous reset in the middle of a move
        home_now();
        @(negedge clk);
        cmd_target = 16'sd1000;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (20) @(negedge clk);
        chk1("mid_motor", motor_en, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk1("arst_motor", motor_en, 1'b0);
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_homed", homed, 1'b0);
        chk1("arst_pos_clear", pos_clear, 1'b0);
        chk1("arst_cmd_ready", cmd_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) begin
            cmd_valid = 1'b1;
            #1;
            chk1("post_rst_ready", cmd_ready, 1'b0);
            @(negedge clk);
            chk1("post_rst_busy", busy, 1'b0);
            chk1("post_rst_clear", pos_clear, 1'b0);
        end
        cmd_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/encoder_move_sequencer.md
# encoder_move_sequencer

Closed-loop move sequencer for one quadrature-encoded axis: homes the axis against a home switch, zeroes the quadrature decoder, then accepts target-position commands and drives motor enable/direction until the decoder's position settles within a deadband. It sits between the command/host side and the quadrature decoder plus motor driver, and owns the decoder's clear input.

## Interface
- `POS_W`, 16, width of signed position/target
- `TMO_W`, 20, width of timeout counter and limit
- `DEADBAND`, 2, allowed |target − position| counted as "on target"
- `SETTLE_CYCLES`, 8, consecutive in-deadband cycles required for completion
- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-high
- `home_req` in 1: level; request homing
- `cmd_valid` in 1: target command valid
- `cmd_ready` out 1: target command accepted when `cmd_valid && cmd_ready`
- `cmd_target` in POS_W: signed target position
- `position` in POS_W: signed position from quadrature decoder
- `home_sw` in 1: asynchronous home switch, active-high
- `timeout_limit` in TMO_W: max cycles per seek/move; 0 disables timeout
- `fault_clr` in 1: leave FAULT
- `pos_clear` out 1: one-cycle pulse clearing decoder position
- `motor_en` out 1: drive motor
- `motor_dir` out 1: 1 = CW (position increasing), 0 = CCW
- `busy` out 1: high in HOME_SEEK, HOME_CLEAR, MOVE, SETTLE
- `done` out 1: one-cycle pulse on move completion
- `homed` out 1: high once homing completes, cleared by reset or FAULT
- `fault` out 1: high in FAULT
- `fault_code` out 2: 0 none, 1 home timeout, 2 move timeout; holds until `fault_clr`

## Operation
- States: IDLE, HOME_SEEK, HOME_CLEAR, READY, MOVE, SETTLE, FAULT. Reset → IDLE, all outputs 0.
- IDLE: `home_req` → HOME_SEEK. Commands never accepted.
- HOME_SEEK: `motor_en`=1, `motor_dir`=0. Synchronized `home_sw`=1 → HOME_CLEAR. If already 1 on entry, advance next cycle.
- HOME_CLEAR: `pos_clear`=1, `motor_en`=0, for exactly one cycle, then READY; `homed`←1.
- READY: `cmd_ready` = (state==READY) && !`home_req`. `home_req` takes priority over simultaneous `cmd_valid` and goes to HOME_SEEK. On handshake, latch `cmd_target` → MOVE.
- Error: `err` = target − position, computed in POS_W+1 bits signed. No wrap: ±2^(POS_W−1) extremes are exact.
- MOVE: if |err| ≤ DEADBAND → SETTLE (`motor_en`=0). Otherwise `motor_en`=1 and `motor_dir` = (err > 0).
- SETTLE: `motor_en`=0, count consecutive in-deadband cycles. On leaving deadband, reset count → MOVE. When count reaches SETTLE_CYCLES → READY with `done`=1 that cycle.
- Timeout: counter clears on entering HOME_SEEK or MOVE (from READY) and runs through HOME_SEEK, or MOVE+SETTLE. Count == `timeout_limit` (nonzero) → FAULT with code 1 or 2 respectively.
- FAULT: `motor_en`=0, `homed`=0, `cmd_ready`=0. `fault_clr` → IDLE, `fault_code`←0.
- `reset` mid-move: immediate return to IDLE and `homed`=0. `pos_clear` is not issued.

## Timing
- All outputs registered (Moore). They reflect the new state one cycle after the transition condition is sampled.
- `home_sw` is passed through a 2-flop synchronizer, so there are 2 cycles of latency before HOME_SEEK sees it.
- The handshake cycle is the cycle where `cmd_valid && cmd_ready`. MOVE is entered the next cycle, and `motor_en` is first asserted the cycle after that, if outside the deadband.
- A target already within the deadband completes in 1 (MOVE) + SETTLE_CYCLES cycles, with `done` in the final cycle.
- `cmd_target` is ignored outside the handshake cycle.

## Structure
- Package `encoder_ctrl_pkg`: state enum, fault-code constants (FAULT_NONE, FAULT_HOME_TMO, FAULT_MOVE_TMO), direction constants DIR_CW/DIR_CCW.
- Sub-module `sync_2ff` for `home_sw`, reusable for the encoder A/B inputs.
- Single FSM, timeout counter, settle counter, and error subtractor live in the top module.

## Test plan
- Reset with `home_sw`=0, then `home_req` pulse; raise `home_sw` after 50 cycles → `motor_dir`=0 during seek; one `pos_clear` pulse; `homed`=1; `cmd_ready`=1.
- Homed, target=+40, `position` ramps 0→40 by 1 per 4 cycles → `motor_dir`=1 until |err|≤2; `done` exactly SETTLE_CYCLES cycles after entering deadband; back to READY.
- Target=−100 from 0 → `motor_dir`=0; position overshoots to −97 after first reaching −99 → SETTLE aborts to MOVE, and `done` is only after 8 consecutive in-band cycles.
- `timeout_limit`=100, `home_sw` held 0 → FAULT at cycle 100 of seek, `fault_code`=1, `motor_en`=0; `fault_clr` → IDLE, code 0.
- In READY, assert `home_req` and `cmd_valid` together → `cmd_ready`=0, no command latched, HOME_SEEK entered.
- `reset` asserted mid-MOVE → outputs 0 asynchronously, state IDLE, `homed`=0; `cmd_valid` afterwards is not accepted.
